// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared pointer type and Gray/binary conversion for both FIFO pointer domains
package fifo_pkg;

   localparam int ADDR_WIDTH = 6;

   typedef logic [ADDR_WIDTH:0] ptr_t;

   // Both helpers work on a zero-extended 32-bit word, so any pointer width up to 32 bits can share them.
   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      b = g;
      for (int s = 1; s < 32; s++) begin
         b = b ^ (g >> s);
      end
      return b;
   endfunction

endpackage

// File: rtl/rptr_empty.sv
// rtl/rptr_empty.sv - read-domain pointer, empty/almost-empty flags and fill count for the async FIFO
module rptr_empty #(
   parameter int ADDR_WIDTH = fifo_pkg::ADDR_WIDTH,
   parameter int AE_LEVEL   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH:0]   wptr_sync,
   output logic [ADDR_WIDTH:0]   rptr,
   output logic [ADDR_WIDTH-1:0] raddr,
   output logic                  empty,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   rd_count,
   output logic                  rd_valid,
   output logic                  underflow
);

   import fifo_pkg::*;

   localparam int PW = ADDR_WIDTH + 1;

   logic [ADDR_WIDTH:0] rbin;
   logic [ADDR_WIDTH:0] rbin_next;
   logic [ADDR_WIDTH:0] rgray_next;
   logic [ADDR_WIDTH:0] wbin;
   logic [ADDR_WIDTH:0] fill_next;
   logic                rd_acc;

   // Flags are computed from the next pointer so the last read raises empty on the same edge.
   always_comb begin
      rd_acc     = rd_en & ~empty;
      rbin_next  = rbin + PW'(rd_acc);
      rgray_next = PW'(bin2gray(32'(rbin_next)));
      wbin       = PW'(gray2bin(32'(wptr_sync)));
      fill_next  = wbin - rbin_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rbin         <= '0;
         rptr         <= '0;
         empty        <= 1'b1;
         almost_empty <= 1'b1;
         rd_count     <= '0;
         rd_valid     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         rbin         <= rbin_next;
         rptr         <= rgray_next;
         empty        <= (rgray_next == wptr_sync);
         almost_empty <= (fill_next <= PW'(AE_LEVEL));
         rd_count     <= fill_next;
         rd_valid     <= rd_acc;
         underflow    <= underflow | (rd_en & empty);
      end
   end

   assign raddr = rbin[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_rptr_empty.sv
// tb/tb_rptr_empty.sv - self-checking bench for rptr_empty against an entry-counting reference model
module tb_rptr_empty;

   localparam int AW = 6;
   localparam int AE = 4;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst;
   logic          rd_en;
   logic [AW:0]   wptr_sync;
   logic [AW:0]   rptr;
   logic [AW-1:0] raddr;
   logic          empty;
   logic          almost_empty;
   logic [AW:0]   rd_count;
   logic          rd_valid;
   logic          underflow;

   int n_checks = 0;
   int n_fail   = 0;

   // Total entries written and read since reset, as plain integers.
   int w_total  = 0;
   int rd_total = 0;

   int  exp_count;
   bit  exp_empty, exp_ae, exp_valid, exp_uf;
   bit  chk_on = 1'b0;
   bit  last_rst = 1'b1;
   logic [AW:0] prev_rptr;
   bit  seen_wrap;

   rptr_empty #(.ADDR_WIDTH(AW), .AE_LEVEL(AE)) dut (
      .clk          (clk),
      .rst          (rst),
      .rd_en        (rd_en),
      .wptr_sync    (wptr_sync),
      .rptr         (rptr),
      .raddr        (raddr),
      .empty        (empty),
      .almost_empty (almost_empty),
      .rd_count     (rd_count),
      .rd_valid     (rd_valid),
      .underflow    (underflow)
   );

   always #5 clk = ~clk;

   function automatic logic [AW:0] gray(input int n);
      logic [AW:0] b;
      b = (AW+1)'(n % (2*DEPTH));
      return b ^ (b >> 1);
   endfunction

   assign wptr_sync = gray(w_total);

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a read is taken only when the FIFO held something before the edge.
   always @(posedge clk) begin
      last_rst <= rst;
      if (rst) begin
         rd_total  = 0;
         exp_count = 0;
         exp_empty = 1'b1;
         exp_ae    = 1'b1;
         exp_valid = 1'b0;
         exp_uf    = 1'b0;
      end else begin
         bit acc;
         acc       = rd_en && !exp_empty;
         exp_uf    = exp_uf || (rd_en && exp_empty);
         rd_total  = rd_total + int'(acc);
         exp_count = w_total - rd_total;
         exp_empty = (exp_count == 0);
         exp_ae    = (exp_count <= AE);
         exp_valid = acc;
      end
      chk_on <= 1'b1;
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("rptr", int'(rptr), int'(gray(rd_total)));
         chk("raddr", int'(raddr), rd_total % DEPTH);
         chk("rd_count", int'(rd_count), exp_count);
         chk("empty", int'(empty), int'(exp_empty));
         chk("almost_empty", int'(almost_empty), int'(exp_ae));
         chk("rd_valid", int'(rd_valid), int'(exp_valid));
         chk("underflow", int'(underflow), int'(exp_uf));
         if (!last_rst) begin
            chk("rptr_hamming_le1", int'($countones(rptr ^ prev_rptr) <= 1), 1);
            if (prev_rptr != rptr && raddr == '0 && prev_rptr == gray(DEPTH - 1))
               seen_wrap = 1'b1;
            if (prev_rptr != rptr && raddr == '0 && prev_rptr == gray(2*DEPTH - 1))
               seen_wrap = 1'b1;
         end
         prev_rptr = rptr;
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; rd_en = 1'b0; w_total = 0;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; rd_en = 1'b0; w_total = 0;
      seen_wrap = 1'b0;
      tick(); tick();
      rst = 1'b0;
      chk("lit_reset_empty", int'(empty), 1);
      chk("lit_reset_rptr", int'(rptr), 0);
      chk("lit_reset_count", int'(rd_count), 0);
      chk("lit_reset_ae", int'(almost_empty), 1);
      chk("lit_reset_uf", int'(underflow), 0);

      // Reads against an empty FIFO are rejected and flag underflow.
      rd_en = 1'b1;
      tick();
      chk("lit_uf_first_edge", int'(underflow), 1);
      chk("lit_uf_valid", int'(rd_valid), 0);
      chk("lit_uf_rptr", int'(rptr), 0);
      tick(); tick();

      rd_en = 1'b0; w_total = 5;
      tick();
      chk("lit_fill5_count", int'(rd_count), 5);
      chk("lit_fill5_empty", int'(empty), 0);
      chk("lit_fill5_ae", int'(almost_empty), 0);
      rd_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("lit_drain_raddr", int'(raddr), i);
         tick();
         chk("lit_drain_count", int'(rd_count), 4 - i);
         chk("lit_drain_ae", int'(almost_empty), 1);
         chk("lit_drain_empty", int'(empty), int'(i == 4));
      end
      tick();
      chk("lit_sixth_rejected_valid", int'(rd_valid), 0);
      chk("lit_sixth_rejected_rptr", int'(rptr), 7);

      // Simultaneous read and write keep the count steady.
      rd_en = 1'b0; w_total = 8;
      tick();
      chk("lit_simul_pre_count", int'(rd_count), 3);
      rd_en = 1'b1; w_total = 9;
      tick();
      chk("lit_simul_count", int'(rd_count), 3);
      chk("lit_simul_valid", int'(rd_valid), 1);

      // Full FIFO from rbin = 0.
      do_reset();
      w_total = DEPTH;
      tick();
      chk("lit_full_count", int'(rd_count), 64);
      chk("lit_full_empty", int'(empty), 0);
      chk("lit_full_ae", int'(almost_empty), 0);

      // Reset mid-burst at count 10 after an underflow.
      do_reset();
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0; w_total = 10;
      tick();
      rd_en = 1'b1; w_total = 11;
      tick();
      chk("lit_burst_count", int'(rd_count), 10);
      chk("lit_burst_uf", int'(underflow), 1);
      rst = 1'b1; w_total = 0;
      tick();
      chk("lit_midrst_count", int'(rd_count), 0);
      chk("lit_midrst_empty", int'(empty), 1);
      chk("lit_midrst_valid", int'(rd_valid), 0);
      chk("lit_midrst_uf", int'(underflow), 0);
      chk("lit_midrst_raddr", int'(raddr), 0);

      // Lockstep wrap: 130 reads carry the pointer past 127 -> 0.
      rst = 1'b0; rd_en = 1'b0; w_total = 1;
      tick();
      rd_en = 1'b1;
      for (int i = 0; i < 130; i++) begin
         w_total++;
         tick();
      end
      chk("lit_wrap_rptr", int'(rptr), 3);
      chk("lit_wrap_raddr", int'(raddr), 2);
      chk("lit_wrap_seen", int'(seen_wrap), 1);

      // Randomized traffic, never writing beyond the FIFO depth.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         rd_en = ($urandom_range(0, 99) < 55);
         if ((w_total - rd_total) < DEPTH && $urandom_range(0, 99) < 50)
            w_total++;
         if ($urandom_range(0, 999) == 0) rst = 1'b1;
         tick();
         if (rst) begin
            rst = 1'b0;
            w_total = 0;
         end
      end
      rd_en = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rptr_empty.md
# rptr_empty

Read-side pointer and empty-flag generator for the async FIFO, in the read clock domain. Advances the binary and Gray read pointers on accepted reads, drives the RAM read address, and compares the local pointer against the synchronized Gray write pointer to produce `empty`, `almost_empty` and a fill count. Its Gray `rptr` output crosses to the write domain through the team's pointer synchronizer, completing the read half of the pointer-exchange protocol.

## Interface
- `ADDR_WIDTH`, 6, RAM address width; depth = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- `AE_LEVEL`, 4, `almost_empty` asserts when fill count <= AE_LEVEL.
- `clk`  in  1  read-domain clock; one clock, all logic on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `rd_en`  in  1  read request from consumer.
- `wptr_sync`  in  ADDR_WIDTH+1  Gray write pointer, already synchronized into this domain.
- `rptr`  out  ADDR_WIDTH+1  Gray read pointer, registered, to write-domain synchronizer.
- `raddr`  out  ADDR_WIDTH  RAM read address = low bits of binary read pointer.
- `empty`  out  1  FIFO empty, registered.
- `almost_empty`  out  1  fill count <= AE_LEVEL, registered.
- `rd_count`  out  ADDR_WIDTH+1  entries available (0..2^ADDR_WIDTH), registered.
- `rd_valid`  out  1  a read was accepted on the previous edge; aligns with registered RAM data.
- `underflow`  out  1  sticky: `rd_en` seen while `empty`.

## Operation
- Accept: `rd_acc = rd_en & ~empty`. Rejected reads change no pointer.
- `rbin_next = rbin + rd_acc` (modulo 2^(ADDR_WIDTH+1)); `rgray_next = rbin_next ^ (rbin_next >> 1)`.
- On clk: `rbin <= rbin_next`, `rptr <= rgray_next`.
- `empty <= (rgray_next == wptr_sync)` — Gray compare, all ADDR_WIDTH+1 bits.
- `wbin = gray2bin(wptr_sync)`; `rd_count <= wbin - rbin_next` (unsigned, ADDR_WIDTH+1 bits, wraps naturally).
- `almost_empty <= (wbin - rbin_next) <= AE_LEVEL`; includes empty case.
- `rd_valid <= rd_acc`.
- `underflow <= underflow | (rd_en & empty)`; cleared only by `rst`.
- `raddr = rbin[ADDR_WIDTH-1:0]` (combinational from register).

## Timing
- Reset (`rst` high at posedge): rbin=0, `rptr`=0, `raddr`=0, `empty`=1, `almost_empty`=1, `rd_count`=0, `rd_valid`=0, `underflow`=0. Applies mid-operation regardless of `rd_en`.
- Read accepted at edge N: `raddr`/`rptr` advance at N; `rd_valid`=1 during cycle N..N+1.
- Last entry read at edge N: `empty`=1 from N (no extra cycle, next-pointer compare); further `rd_en` rejected.
- `wptr_sync` change: `empty`/`rd_count`/`almost_empty` reflect it one edge later. Synchronizer latency is outside this block and only makes `empty` pessimistic, never optimistic.
- Simultaneous read and `wptr_sync` advance: both applied in the same next-state computation; count unchanged if both +1.
- Wrap: rbin 2^(ADDR_WIDTH+1)-1 -> 0; Gray MSB distinguishes laps; `raddr` wraps 63 -> 0 at ADDR_WIDTH=6.
- `rptr` changes at most one bit per edge (Gray property); required for safe crossing.

## Structure
- Shared package `fifo_pkg`: `ADDR_WIDTH` default, `bin2gray`/`gray2bin` functions (parameterized via width), pointer typedef `ptr_t` = logic [ADDR_WIDTH:0]. Write side reuses the same package.
- No sub-module; single flat always_ff plus combinational next-state logic.

## Test plan
- Reset then idle, `wptr_sync`=0, `rd_en`=1 for 3 cycles -> `empty`=1, `rptr`=0, `underflow`=1 after first edge, `rd_valid`=0.
- `wptr_sync`=bin2gray(5) -> next edge `empty`=0, `rd_count`=5, `almost_empty`=0; read 5 back-to-back -> `raddr` 0..4, `rd_count` 4,3,2,1,0, `almost_empty`=1 from count 4, `empty`=1 at fifth edge, sixth `rd_en` rejected.
- Full wrap: feed 130 writes/reads in lockstep at ADDR_WIDTH=6 -> `raddr` wraps 63->0, rbin 127->0, every `rptr` transition has Hamming distance 1.
- Simultaneous: count=3, `rd_en`=1 while `wptr_sync` advances by 1 -> `rd_count` stays 3, `rd_valid`=1.
- Full FIFO: `wptr_sync`=bin2gray(64), rbin=0 -> `rd_count`=64, `empty`=0, `almost_empty`=0.
- `rst` asserted mid-burst with `rd_en`=1 and count=10 -> next edge all outputs at reset values, `underflow` cleared.
